// File: rtl/fir_pkg.sv
// Shared constants, FSM state type and width helpers for the symmetric TDM FIR.
package fir_pkg;

    localparam int WD_DEFAULT    = 24;
    localparam int N_TAP_DEFAULT = 32;
    localparam int N_CH_DEFAULT  = 2;
    localparam int CW_DEFAULT    = 18;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        ROUND = 2'd2,
        OUT   = 2'd3
    } state_t;

    // Pre-add (wd+1) times coefficient (cw) gives wd+cw+1 bits; n_tap/2 of
    // those are summed, so log2(n_tap/2) guard bits keep the sum exact.
    function automatic int acc_w(input int wd, input int cw, input int n_tap);
        return wd + cw + 1 + $clog2(n_tap / 2);
    endfunction

    // Channel index width, never narrower than one bit.
    function automatic int ch_w(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

endpackage

// File: rtl/fir_sym_tdm_if.sv
// Sample stream, filtered output stream and coefficient write port of the FIR.
interface fir_sym_tdm_if
    import fir_pkg::*;
#(
    parameter int WD    = WD_DEFAULT,
    parameter int N_TAP = N_TAP_DEFAULT,
    parameter int N_CH  = N_CH_DEFAULT,
    parameter int CW    = CW_DEFAULT
) ();

    localparam int CHW = ch_w(N_CH);
    localparam int AW  = $clog2(N_TAP / 2);

    logic [WD-1:0]  sam_in;
    logic [CHW-1:0] sam_ch;
    logic           in_valid;
    logic           in_ready;

    logic [WD-1:0]  data_out;
    logic [CHW-1:0] out_ch;
    logic           out_valid;
    logic           out_ready;

    logic           coef_we;
    logic [AW-1:0]  coef_addr;
    logic [CW-1:0]  coef_data;
    logic           coef_ack;

    // Producer/consumer side: drives samples, coefficients and out_ready.
    modport master (
        output sam_in, sam_ch, in_valid,
        input  in_ready,
        input  data_out, out_ch, out_valid,
        output out_ready,
        output coef_we, coef_addr, coef_data,
        input  coef_ack
    );

    // Filter side.
    modport slave (
        input  sam_in, sam_ch, in_valid,
        output in_ready,
        output data_out, out_ch, out_valid,
        input  out_ready,
        input  coef_we, coef_addr, coef_data,
        output coef_ack
    );

endinterface

// File: rtl/fir_round_sat.sv
// Round-half-up arithmetic right shift followed by saturation to OUT_W bits.
module fir_round_sat #(
    parameter int IN_W  = 47,
    parameter int OUT_W = 24,
    parameter int SHIFT = 17
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout
);

    // One extra bit so the rounding bias can never wrap the input.
    localparam logic signed [IN_W:0] RND_BIAS = (IN_W + 1)'(1) << (SHIFT - 1);
    localparam logic signed [IN_W:0] MAX_V =
        {{(IN_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [IN_W:0] MIN_V =
        {{(IN_W - OUT_W + 2){1'b1}}, {(OUT_W - 1){1'b0}}};

    function automatic logic signed [IN_W:0] round_shift(input logic signed [IN_W-1:0] v);
        logic signed [IN_W:0] b;
        b = (IN_W + 1)'(v) + RND_BIAS;
        return b >>> SHIFT;
    endfunction

    function automatic logic signed [OUT_W-1:0] saturate(input logic signed [IN_W:0] v);
        if (v > MAX_V) begin
            return MAX_V[OUT_W-1:0];
        end else if (v < MIN_V) begin
            return MIN_V[OUT_W-1:0];
        end
        return v[OUT_W-1:0];
    endfunction

    assign dout = saturate(round_shift(din));

endmodule

// File: rtl/fir_sym_tdm.sv
// Time-multiplexed symmetric FIR: one shared MAC folds the tap pairs of the
// selected channel, then rounds/saturates and hands the result out.
module fir_sym_tdm
    import fir_pkg::*;
#(
    parameter int WD    = WD_DEFAULT,
    parameter int N_TAP = N_TAP_DEFAULT,
    parameter int N_CH  = N_CH_DEFAULT,
    parameter int CW    = CW_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    fir_sym_tdm_if.slave bus
);

    localparam int HALF  = N_TAP / 2;
    localparam int CHW   = ch_w(N_CH);
    localparam int AW    = $clog2(HALF);
    localparam int TW    = $clog2(N_TAP);
    localparam int ACC_W = acc_w(WD, CW, N_TAP);
    localparam int PW    = WD + CW + 1;

    localparam logic [CHW:0]  NCH_V  = (CHW + 1)'(N_CH);
    localparam logic [AW-1:0] K_LAST = AW'(HALF - 1);

    state_t                   state;
    logic [AW-1:0]            k_p1;
    logic [CHW-1:0]           ch_p0;
    logic signed [ACC_W-1:0]  acc_p1;

    logic signed [WD-1:0]     dl   [N_CH][N_TAP];
    logic signed [CW-1:0]     coef [HALF];

    logic                     accept;
    logic                     in_range;
    logic                     coef_acc;

    logic [TW-1:0]            lo_idx;
    logic [TW-1:0]            hi_idx;
    logic signed [WD-1:0]     x_lo;
    logic signed [WD-1:0]     x_hi;
    logic signed [CW-1:0]     c_k;
    logic signed [WD:0]       pre;
    logic signed [PW-1:0]     prod;
    logic signed [ACC_W-1:0]  acc_next;
    logic signed [WD-1:0]     rnd;

    assign accept   = bus.in_valid && bus.in_ready;
    assign in_range = {1'b0, bus.sam_ch} < NCH_V;
    // A sample acceptance on the same edge wins over a coefficient write.
    assign coef_acc = bus.coef_we && (state == IDLE) && !accept;

    // Tap pair k and N_TAP-1-k share coefficient k, so add them before multiplying.
    assign lo_idx   = TW'(k_p1);
    assign hi_idx   = TW'(N_TAP - 1) - lo_idx;
    assign x_lo     = dl[ch_p0][lo_idx];
    assign x_hi     = dl[ch_p0][hi_idx];
    assign c_k      = coef[k_p1];
    assign pre      = (WD + 1)'(x_lo) + (WD + 1)'(x_hi);
    assign prod     = PW'(pre) * PW'(c_k);
    assign acc_next = acc_p1 + ACC_W'(prod);

    fir_round_sat #(
        .IN_W  (ACC_W),
        .OUT_W (WD),
        .SHIFT (CW - 1)
    ) u_round_sat (
        .din  (acc_p1),
        .dout (rnd)
    );

    // Control FSM: accept, fold N_TAP/2 tap pairs, round, then hold the result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            k_p1          <= '0;
            ch_p0         <= '0;
            acc_p1        <= '0;
            bus.in_ready  <= 1'b0;
            bus.data_out  <= '0;
            bus.out_ch    <= '0;
            bus.out_valid <= 1'b0;
            bus.coef_ack  <= 1'b0;
        end else begin
            bus.coef_ack <= coef_acc;
            unique case (state)
                IDLE: begin
                    bus.in_ready <= 1'b1;
                    // Out-of-range channels are consumed here without leaving IDLE.
                    if (accept && in_range) begin
                        bus.in_ready <= 1'b0;
                        ch_p0        <= bus.sam_ch;
                        acc_p1       <= '0;
                        k_p1         <= '0;
                        state        <= MAC;
                    end
                end
                MAC: begin
                    acc_p1 <= acc_next;
                    k_p1   <= k_p1 + AW'(1);
                    if (k_p1 == K_LAST) begin
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    bus.data_out  <= rnd;
                    bus.out_ch    <= ch_p0;
                    bus.out_valid <= 1'b1;
                    state         <= OUT;
                end
                OUT: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Per-channel delay lines and the shared half-length coefficient table.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < N_CH; c++) begin
                for (int i = 0; i < N_TAP; i++) begin
                    dl[c][i] <= '0;
                end
            end
            for (int i = 0; i < HALF; i++) begin
                coef[i] <= '0;
            end
        end else begin
            if (accept && in_range) begin
                for (int c = 0; c < N_CH; c++) begin
                    if (CHW'(c) == bus.sam_ch) begin
                        dl[c][0] <= bus.sam_in;
                        for (int i = 1; i < N_TAP; i++) begin
                            dl[c][i] <= dl[c][i-1];
                        end
                    end
                end
            end
            if (coef_acc) begin
                coef[bus.coef_addr] <= bus.coef_data;
            end
        end
    end

endmodule

// File: tb/tb_fir_sym_tdm.sv
// Scoreboard bench for fir_sym_tdm: stimulus pushes expected results from a
// direct-convolution model, a monitor pops and compares on each transfer.
module tb_fir_sym_tdm;

    localparam int WD    = 24;
    localparam int N_TAP = 8;
    localparam int N_CH  = 2;
    localparam int CW    = 18;
    localparam int HALF  = N_TAP / 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    fir_sym_tdm_if #(.WD(WD), .N_TAP(N_TAP), .N_CH(N_CH), .CW(CW)) bus ();

    fir_sym_tdm #(.WD(WD), .N_TAP(N_TAP), .N_CH(N_CH), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic        ch;
        logic [23:0] d;
    } exp_t;

    exp_t   exp_q[$];
    longint hist[N_CH][N_TAP];
    longint c_m[HALF];
    int     checks   = 0;
    int     failures = 0;
    int     n_xfer   = 0;
    int     bp_mode  = 0;
    logic [23:0] imp [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Full symmetric impulse response h[i] = c[min(i, N_TAP-1-i)], plain convolution.
    function automatic logic [23:0] model_out(input int ch);
        longint y;
        y = 0;
        for (int i = 0; i < N_TAP; i++) begin
            int k;
            k = (i < HALF) ? i : (N_TAP - 1 - i);
            y += hist[ch][i] * c_m[k];
        end
        y = (y + (longint'(1) <<< (CW - 2))) >>> (CW - 1);
        if (y > 64'sd8388607) y = 64'sd8388607;
        else if (y < -64'sd8388608) y = -64'sd8388608;
        return y[23:0];
    endfunction

    task automatic clear_model();
        for (int c = 0; c < N_CH; c++)
            for (int i = 0; i < N_TAP; i++) hist[c][i] = 0;
        for (int i = 0; i < HALF; i++) c_m[i] = 0;
    endtask

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send(input int ch, input logic [23:0] val, input bit use_exp, input logic [23:0] expv);
        exp_t e;
        int   t;
        for (int i = N_TAP - 1; i > 0; i--) hist[ch][i] = hist[ch][i-1];
        hist[ch][0] = longint'($signed(val));
        e.ch = 1'(ch);
        e.d  = use_exp ? expv : model_out(ch);
        exp_q.push_back(e);
        bus.sam_in   = val;
        bus.sam_ch   = 1'(ch);
        bus.in_valid = 1'b1;
        for (t = 0; t < 300; t++) begin
            @(negedge clk);
            if (bus.in_ready) break;
        end
        if (t >= 300) chk("in_ready_timeout", {63'd0, bus.in_ready}, 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic write_coef(input int addr, input logic [17:0] data, input bit exp_ack);
        bus.coef_we   = 1'b1;
        bus.coef_addr = 2'(addr);
        bus.coef_data = data;
        @(posedge clk);
        #1;
        bus.coef_we = 1'b0;
        chk("coef_ack", {63'd0, bus.coef_ack}, {63'd0, exp_ack});
        if (exp_ack) c_m[addr] = longint'($signed(data));
    endtask

    task automatic wait_drain();
        int t;
        for (t = 0; t < 3000; t++) begin
            if (exp_q.size() == 0 && bus.in_ready) break;
            @(posedge clk);
            #1;
        end
        if (t >= 3000) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    // out_ready driver: 0 = held high, 1 = held low, otherwise random.
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (bp_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = 1'b0;
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: every transfer must match the oldest expected entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && bus.out_valid && bus.out_ready) begin
                n_xfer++;
                if (exp_q.size() == 0) begin
                    chk("extra_output_valid", {63'd0, bus.out_valid}, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("data_out", {40'd0, bus.data_out}, {40'd0, e.d});
                    chk("out_ch", {63'd0, bus.out_ch}, {63'd0, e.ch});
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        int   hold_x;
        bit   seen;
        logic [23:0] held;

        imp[0] = 24'h040000; imp[1] = 24'h020000; imp[2] = 24'h010000; imp[3] = 24'h008000;
        imp[4] = 24'h008000; imp[5] = 24'h010000; imp[6] = 24'h020000; imp[7] = 24'h040000;
        bus.sam_in = '0; bus.sam_ch = '0; bus.in_valid = 1'b0;
        bus.coef_we = 1'b0; bus.coef_addr = '0; bus.coef_data = '0;
        clear_model();

        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
        chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_data_out", {40'd0, bus.data_out}, 64'd0);
        chk("rst_out_ch", {63'd0, bus.out_ch}, 64'd0);
        chk("rst_coef_ack", {63'd0, bus.coef_ack}, 64'd0);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready_first_edge", {63'd0, bus.in_ready}, 64'd1);

        // Impulse response with latency and throughput measurement.
        write_coef(0, 18'h08000, 1);
        write_coef(1, 18'h04000, 1);
        write_coef(2, 18'h02000, 1);
        write_coef(3, 18'h01000, 1);
        send(0, 24'h100000, 1, imp[0]);
        for (n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) break;
        end
        chk("latency_out_valid", 64'(n), 64'(HALF + 1));
        while (n <= 40 && !bus.in_ready) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency_in_ready", 64'(n), 64'(HALF + 2));
        for (int i = 1; i < 8; i++) send(0, 24'h0, 1, imp[i]);
        send(0, 24'h0, 1, 24'h0);

        // Channel isolation: zero ch1 samples interleaved with the ch0 impulse.
        for (int i = 0; i < 8; i++) begin
            send(0, (i == 0) ? 24'h100000 : 24'h0, 1, imp[i]);
            send(1, 24'h0, 1, 24'h0);
        end

        // Coefficient write during MAC is dropped.
        send(1, 24'h012345, 0, 24'h0);
        write_coef(0, 18'h3FFFF, 0);
        @(posedge clk);
        #1;
        chk("coef_ack_mac_late", {63'd0, bus.coef_ack}, 64'd0);
        send(1, 24'h054321, 0, 24'h0);
        wait_drain();

        // Back-pressure: result held for 10 cycles, then exactly one transfer.
        bp_mode = 1;
        send(0, 24'h0ABCDE, 0, 24'h0);
        for (n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) break;
        end
        chk("bp_latency", 64'(n), 64'(HALF + 1));
        held   = bus.data_out;
        hold_x = n_xfer;
        repeat (10) begin
            @(posedge clk);
            #1;
            chk("bp_data_stable", {40'd0, bus.data_out}, {40'd0, held});
            chk("bp_in_ready", {63'd0, bus.in_ready}, 64'd0);
            chk("bp_out_valid", {63'd0, bus.out_valid}, 64'd1);
        end
        bp_mode = 0;
        @(posedge clk);
        #1;
        chk("bp_released_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("bp_one_transfer", 64'(n_xfer), 64'(hold_x + 1));
        wait_drain();

        // Saturation at both rails once the line is full.
        for (int a = 0; a < HALF; a++) write_coef(a, 18'h1FFFF, 1);
        for (int i = 0; i < 8; i++) send(0, 24'h7FFFFF, (i == 7), 24'h7FFFFF);
        for (int i = 0; i < 8; i++) send(0, 24'h800000, (i == 7), 24'h800000);
        wait_drain();

        // Random coefficients, samples, channels and back-pressure.
        for (int a = 0; a < HALF; a++) write_coef(a, 18'($urandom), 1);
        bp_mode = 2;
        repeat (60) send(int'($urandom_range(0, 1)), 24'($urandom), 0, 24'h0);
        wait_drain();
        bp_mode = 0;
        @(posedge clk);
        #1;

        // Reset in the middle of MAC aborts and clears coefficients.
        send(0, 24'h100000, 0, 24'h0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("abort_in_ready", {63'd0, bus.in_ready}, 64'd0);
        chk("abort_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("abort_data_out", {40'd0, bus.data_out}, 64'd0);
        exp_q.delete();
        clear_model();
        @(posedge clk);
        #3;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_in_ready_first_edge", {63'd0, bus.in_ready}, 64'd1);
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen = 1'b1;
        end
        chk("abort_no_output", {63'd0, seen}, 64'd0);
        for (int i = 0; i < 8; i++) send(0, (i == 0) ? 24'h100000 : 24'h0, 1, 24'h0);
        wait_drain();

        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
